// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// Control side drives operands and launch strobes; the unit returns Busy/Done and HI/LO.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             HiWriteEn;
  logic             LoWriteEn;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, SrcA, SrcB, HiWriteEn, LoWriteEn,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, HiWriteEn, LoWriteEn,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU, one result bit per cycle, owning HI/LO; latency WIDTH+2 edges from Start to Done.
// No queueing: Start and MTHI/MTLO are ignored while Busy; the control path must stall on Busy.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    b_d        = b_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    a_neg      = 1'b0;
    b_neg      = 1'b0;
    sum        = '0;
    shifted    = '0;
    diff       = '0;
    prod       = '0;
    quo_fix    = '0;
    rem_fix    = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.HiWriteEn) hi_d = bus.SrcA;
        if (bus.LoWriteEn) lo_d = bus.SrcA;
        if (bus.Start) begin
          // Op[0]=0 selects the signed flavour; run on magnitudes and fix signs at the end
          a_neg      = ~bus.Op[0] & bus.SrcA[WIDTH-1];
          b_neg      = ~bus.Op[0] & bus.SrcB[WIDTH-1];
          is_div_d   = bus.Op[1];
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (bus.SrcB == '0);
          quo_d      = a_neg ? -bus.SrcA : bus.SrcA;
          b_d        = b_neg ? -bus.SrcB : bus.SrcB;
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          shifted = {rem_q, quo_q[WIDTH-1]};
          diff    = shifted - {1'b0, b_q};
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // {rem,quo} is the running product; multiplier bits drain out of quo's LSB
          sum          = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : '0);
          {rem_d, quo_d} = {sum, quo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          quo_fix = neg_res_q ? -quo_q : quo_q;
          rem_fix = neg_rem_q ? -rem_q : rem_q;
          lo_d    = div_zero_q ? '1 : quo_fix;
          hi_d    = rem_fix;
        end else begin
          prod = {rem_q, quo_q};
          if (neg_res_q) prod = ~prod + 1'b1;
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      b_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level HI/LO model with a countdown for latency, checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.Clk(clk), .Reset(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [W-1:0]   m_hi = '0, m_lo = '0;
  logic [2*W-1:0] m_res = '0;
  int             m_left = 0;
  logic           m_done = 1'b0;

  // {HI,LO} straight from the arithmetic definition of each op
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    logic [31:0] q, r;
    case (op)
      2'd0: begin p = longint'($signed(a)) * longint'($signed(b)); u = p; end
      2'd1: u = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 32'd0) u = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) u = {32'd0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          u = {r, q};
        end
      end
      default: begin
        if (b == 32'd0) u = {a, 32'hFFFF_FFFF};
        else u = {a % b, a / b};
      end
    endcase
    return u;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
      end else begin
        if (bus.HiWriteEn) m_hi <= bus.SrcA;
        if (bus.LoWriteEn) m_lo <= bus.SrcA;
        if (bus.Start) begin
          m_res  <= ref_op(bus.Op, bus.SrcA, bus.SrcB);
          m_left <= W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({bus.Busy, bus.Done, bus.Hi, bus.Lo} !== {(m_left > 0), m_done, m_hi, m_lo}) begin
        fails++;
        $display("FAIL cycle_model t=%0t: busy/done/hi/lo got %b %b %h %h expected %b %b %h %h",
                 $time, bus.Busy, bus.Done, bus.Hi, bus.Lo, (m_left > 0), m_done, m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.SrcA = a; bus.SrcB = b;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  // cnt = negedges seen since the launching edge; returns 34 for an on-time Done
  task automatic wait_done(input int start_cnt, output int cnt);
    cnt = start_cnt;
    while (!bus.Done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($signed($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  int lat;
  int seen_done;
  logic [31:0] hi_before;

  initial begin
    bus.Start = 1'b0; bus.Op = 2'd0; bus.SrcA = '0; bus.SrcB = '0;
    bus.HiWriteEn = 1'b0; bus.LoWriteEn = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", {30'd0, bus.Busy, bus.Done, bus.Hi}, 64'd0);
    check("reset_lo", {32'd0, bus.Lo}, 64'd0);
    rst = 1'b0;

    check("model_multu_max", ref_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("model_mult_neg", ref_op(2'd0, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    check("model_div_neg", ref_op(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("model_divu_zero", ref_op(2'd3, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);
    check("model_div_ovf", ref_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, lat);
    check("multu_latency", lat, 34);
    check("multu_result", {bus.Hi, bus.Lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    check("done_one_cycle", {63'd0, bus.Done}, 64'd0);

    launch(2'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(1, lat);
    check("mult_neg", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    launch(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, lat);
    check("div_neg", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    launch(2'd3, 32'd100, 32'd0);
    wait_done(1, lat);
    check("divu_by_zero", {bus.Hi, bus.Lo}, 64'h0000_0064_FFFF_FFFF);
    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, lat);
    check("div_overflow", {bus.Hi, bus.Lo}, 64'h0000_0000_8000_0000);

    // re-pulsed Start with new operands mid-op must be ignored
    launch(2'd3, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.Start = 1'b1; bus.Op = 2'd0; bus.SrcA = 32'd5; bus.SrcB = 32'd5;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done(6, lat);
    check("restart_latency", lat, 34);
    check("restart_ignored", {bus.Hi, bus.Lo}, {32'd2, 32'd14});

    // reset in the middle of a DIVU aborts it without a Done
    launch(2'd3, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {30'd0, bus.Busy, bus.Done, bus.Hi}, 64'd0);
    check("abort_lo", {32'd0, bus.Lo}, 64'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    bus.LoWriteEn = 1'b1; bus.SrcA = 32'h1234;
    @(negedge clk);
    bus.LoWriteEn = 1'b0;
    check("mtlo_idle", {32'd0, bus.Lo}, 64'h1234);
    hi_before = bus.Hi;
    launch(2'd1, 32'd3, 32'd4);
    bus.HiWriteEn = 1'b1; bus.SrcA = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.HiWriteEn = 1'b0;
    check("mthi_busy_ignored", {32'd0, bus.Hi}, {32'd0, hi_before});
    wait_done(2, lat);
    check("mult_small", {bus.Hi, bus.Lo}, {32'd0, 32'd12});
    bus.Start = 1'b1; bus.Op = 2'd1; bus.SrcA = 32'd5; bus.SrcB = 32'd6;
    @(negedge clk);
    bus.Start = 1'b0;
    check("b2b_accepted", {63'd0, bus.Busy}, 64'd1);
    wait_done(1, lat);
    check("b2b_result", {lat, bus.Lo}, {32'd34, 32'd30});

    repeat (6000) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 999) == 0);
      bus.Start     = ($urandom_range(0, 5) == 0);
      bus.Op        = 2'($urandom_range(0, 3));
      bus.SrcA      = pick();
      bus.SrcB      = pick();
      bus.HiWriteEn = ($urandom_range(0, 7) == 0);
      bus.LoWriteEn = ($urandom_range(0, 7) == 0);
    end
    rst = 1'b0; bus.Start = 1'b0; bus.HiWriteEn = 1'b0; bus.LoWriteEn = 1'b0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
